execute_mc: RTL and testbench

//  Parametrised execute stage for the multi-cycle MIPS-subset datapath.

---
 rtl/execute_mc_pkg.sv | 29 ++
 rtl/execute_mc_mul_seq.sv | 60 ++++++
 rtl/execute_mc.sv | 163 ++++++++++++++++
 tb/tb_execute_mc.sv | 242 ++++++++++++++++++++++++
 4 files changed

// File: rtl/execute_mc_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | execute_mc_pkg: opcode/func encodings for the MIPS-subset execute    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
package execute_mc_pkg;

  typedef logic [5:0] opcode_t;
  typedef logic [5:0] func_t;

  localparam opcode_t c_op_rtype = 6'h00;
  localparam opcode_t c_op_addiu = 6'h09;
  localparam opcode_t c_op_andi  = 6'h0C;
  localparam opcode_t c_op_ori   = 6'h0D;

  localparam func_t c_func_sll   = 6'h00;
  localparam func_t c_func_srl   = 6'h02;
  localparam func_t c_func_sra   = 6'h03;
  localparam func_t c_func_multu = 6'h19;
  localparam func_t c_func_addu  = 6'h21;
  localparam func_t c_func_subu  = 6'h23;
  localparam func_t c_func_and   = 6'h24;
  localparam func_t c_func_or    = 6'h25;
  localparam func_t c_func_xor   = 6'h26;
  localparam func_t c_func_slt   = 6'h2A;
  localparam func_t c_func_sltu  = 6'h2B;

endpackage : execute_mc_pkg
`default_nettype wire

// File: rtl/execute_mc_mul_seq.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | execute_mul_seq: iterative shift-add unsigned multiplier, DW steps   |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module execute_mul_seq #(
  parameter int DW = 8
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          start,
  input  logic [DW-1:0] a,
  input  logic [DW-1:0] b,
  output logic          busy,
  output logic          done,
  output logic [DW-1:0] hi,
  output logic [DW-1:0] lo
);

  logic [2*DW-1:0] r_acc;
  logic [2*DW-1:0] r_mcand;
  logic [DW-1:0]   r_mplier;
  logic [DW-1:0]   r_cnt;
  logic            r_busy;
  logic [2*DW-1:0] w_acc_next;

  assign w_acc_next = r_acc + (r_mplier[0] ? r_mcand : '0);

  // The final step's sum is exposed combinationally so the parent can
  // capture the product on the same edge that retires the last step.
  assign busy      = r_busy;
  assign done      = r_busy && (r_cnt == DW'(DW - 1));
  assign {hi, lo}  = w_acc_next;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_acc    <= '0;
      r_mcand  <= '0;
      r_mplier <= '0;
      r_cnt    <= '0;
      r_busy   <= 1'b0;
    end else if (start) begin
      r_acc    <= '0;
      r_mcand  <= {{DW{1'b0}}, a};
      r_mplier <= b;
      r_cnt    <= '0;
      r_busy   <= 1'b1;
    end else if (r_busy) begin
      r_acc    <= w_acc_next;
      r_mcand  <= r_mcand << 1;
      r_mplier <= r_mplier >> 1;
      r_cnt    <= r_cnt + DW'(1);
      if (done) begin
        r_busy <= 1'b0;
      end
    end
  end

endmodule : execute_mul_seq
`default_nettype wire

// File: rtl/execute_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | execute_mc: multi-cycle execute stage, 1-cycle ALU + iterative MULTU |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module execute_mc
  import execute_mc_pkg::*;
#(
  parameter int DW   = 8,
  parameter int IMMW = 16,
  parameter int SHW  = 3
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [5:0]      opcode,
  input  logic [5:0]      func,
  input  logic [DW-1:0]   rsv,
  input  logic [DW-1:0]   rtv,
  input  logic [IMMW-1:0] imm,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [DW-1:0]   result,
  output logic [DW-1:0]   result_hi,
  output logic            instruction_invalid
);

  localparam logic [1:0] c_idle = 2'd0;
  localparam logic [1:0] c_mul  = 2'd1;
  localparam logic [1:0] c_done = 2'd2;

  logic [1:0]    r_state;
  logic [1:0]    w_next_state;
  logic          w_accept;
  logic          w_is_mul;
  logic          w_alu_inv;
  logic [DW-1:0] w_alu_res;
  logic          w_mul_start;
  logic          w_mul_done;
  logic          w_unused_mul_busy;
  logic [DW-1:0] w_mul_hi;
  logic [DW-1:0] w_mul_lo;
  logic [DW-1:0] r_result;
  logic [DW-1:0] r_result_hi;
  logic          r_invalid;

  // Upper immediate bits never reach a DW-wide datapath.
  generate
    if (IMMW > DW) begin : g_imm_pad
      logic w_unused_imm;
      assign w_unused_imm = ^imm[IMMW-1:DW];
    end
  endgenerate

  always_comb begin
    w_alu_res = '0;
    w_alu_inv = 1'b0;
    w_is_mul  = 1'b0;
    case (opcode)
      c_op_rtype: begin
        case (func)
          c_func_addu:  w_alu_res = rsv + rtv;
          c_func_subu:  w_alu_res = rsv - rtv;
          c_func_and:   w_alu_res = rsv & rtv;
          c_func_or:    w_alu_res = rsv | rtv;
          c_func_xor:   w_alu_res = rsv ^ rtv;
          c_func_slt:   w_alu_res = {{(DW-1){1'b0}}, ($signed(rsv) < $signed(rtv))};
          c_func_sltu:  w_alu_res = {{(DW-1){1'b0}}, (rsv < rtv)};
          c_func_sll:   w_alu_res = rtv << rsv[SHW-1:0];
          c_func_srl:   w_alu_res = rtv >> rsv[SHW-1:0];
          c_func_sra:   w_alu_res = $signed(rtv) >>> rsv[SHW-1:0];
          c_func_multu: w_is_mul  = 1'b1;
          default:      w_alu_inv = 1'b1;
        endcase
      end
      c_op_addiu: w_alu_res = rsv + imm[DW-1:0];
      c_op_andi:  w_alu_res = rsv & imm[DW-1:0];
      c_op_ori:   w_alu_res = rsv | imm[DW-1:0];
      default:    w_alu_inv = 1'b1;
    endcase
  end

  assign w_accept = in_valid && in_ready;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state <= c_idle;
    end else begin
      r_state <= w_next_state;
    end
  end

  always_comb begin
    w_next_state = r_state;
    case (r_state)
      c_idle: begin
        if (w_accept) begin
          w_next_state = w_is_mul ? c_mul : c_done;
        end
      end
      c_mul: begin
        if (w_mul_done) begin
          w_next_state = c_done;
        end
      end
      c_done: begin
        if (out_ready) begin
          if (in_valid) begin
            w_next_state = w_is_mul ? c_mul : c_done;
          end else begin
            w_next_state = c_idle;
          end
        end
      end
      default: w_next_state = c_idle;
    endcase
  end

  always_comb begin
    in_ready    = (r_state == c_idle) || ((r_state == c_done) && out_ready);
    out_valid   = (r_state == c_done);
    w_mul_start = w_accept && w_is_mul;
  end

  // Result registers only move on a single-cycle accept or a finishing
  // multiply, so they stay frozen while the consumer stalls.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_result    <= '0;
      r_result_hi <= '0;
      r_invalid   <= 1'b1;
    end else if (w_accept && !w_is_mul) begin
      r_result    <= w_alu_res;
      r_result_hi <= '0;
      r_invalid   <= w_alu_inv;
    end else if ((r_state == c_mul) && w_mul_done) begin
      r_result    <= w_mul_lo;
      r_result_hi <= w_mul_hi;
      r_invalid   <= 1'b0;
    end
  end

  assign result              = r_result;
  assign result_hi           = r_result_hi;
  assign instruction_invalid = r_invalid;

  execute_mul_seq #(
    .DW(DW)
  ) u_mul (
    .clk   (clk),
    .reset (reset),
    .start (w_mul_start),
    .a     (rsv),
    .b     (rtv),
    .busy  (w_unused_mul_busy),
    .done  (w_mul_done),
    .hi    (w_mul_hi),
    .lo    (w_mul_lo)
  );

endmodule : execute_mc
`default_nettype wire

// File: tb/tb_execute_mc.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_execute_mc: table, corner-case and random checks of execute_mc    |
// | Rev 1.0 - initial release                                            |
// +----------------------------------------------------------------------+
module tb_execute_mc;

  typedef struct {
    logic [5:0]  op;
    logic [5:0]  fn;
    logic [7:0]  a;
    logic [7:0]  b;
    logic [15:0] im;
    logic [7:0]  er;
    logic [7:0]  eh;
    logic        ei;
    int          lat;
  } vec_t;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [5:0]  opcode = '0;
  logic [5:0]  func = '0;
  logic [7:0]  rsv = '0;
  logic [7:0]  rtv = '0;
  logic [15:0] imm = '0;
  logic        out_valid;
  logic        out_ready = 1'b1;
  logic [7:0]  result;
  logic [7:0]  result_hi;
  logic        instruction_invalid;

  int checks = 0;
  int errors = 0;

  execute_mc #(.DW(8), .IMMW(16), .SHW(3)) dut (
    .clk                 (clk),
    .reset               (reset),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .opcode              (opcode),
    .func                (func),
    .rsv                 (rsv),
    .rtv                 (rtv),
    .imm                 (imm),
    .out_valid           (out_valid),
    .out_ready           (out_ready),
    .result              (result),
    .result_hi           (result_hi),
    .instruction_invalid (instruction_invalid)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h expected=%0h", nm, act, exp);
    end
  endtask

  // Behavioural reference: plain integer arithmetic on the instruction rules.
  function automatic vec_t model(logic [5:0] op, logic [5:0] fn, logic [7:0] a,
                                 logic [7:0] b, logic [15:0] im);
    vec_t v;
    int ia, ib, sa, sb, s, p, iim;
    ia = int'(a); ib = int'(b); iim = int'(im) % 256;
    sa = (ia >= 128) ? ia - 256 : ia;
    sb = (ib >= 128) ? ib - 256 : ib;
    s  = ia % 8;
    v.op = op; v.fn = fn; v.a = a; v.b = b; v.im = im;
    v.er = 8'h00; v.eh = 8'h00; v.ei = 1'b0; v.lat = 1;
    if (op == 6'h00) begin
      case (fn)
        6'h21: v.er = 8'((ia + ib) % 256);
        6'h23: v.er = 8'((ia - ib + 256) % 256);
        6'h24: v.er = 8'(ia & ib);
        6'h25: v.er = 8'(ia | ib);
        6'h26: v.er = 8'(ia ^ ib);
        6'h2A: v.er = (sa < sb) ? 8'd1 : 8'd0;
        6'h2B: v.er = (ia < ib) ? 8'd1 : 8'd0;
        6'h00: v.er = 8'((ib * (1 << s)) % 256);
        6'h02: v.er = 8'(ib / (1 << s));
        6'h03: v.er = 8'((sb >>> s) & 255);
        6'h19: begin p = ia * ib; v.er = 8'(p % 256); v.eh = 8'(p / 256); v.lat = 9; end
        default: v.ei = 1'b1;
      endcase
    end else if (op == 6'h09) v.er = 8'((ia + iim) % 256);
    else if (op == 6'h0C)     v.er = 8'(ia & iim);
    else if (op == 6'h0D)     v.er = 8'(ia | iim);
    else                      v.ei = 1'b1;
    return v;
  endfunction

  function automatic vec_t mk(logic [5:0] op, logic [5:0] fn, logic [7:0] a, logic [7:0] b,
                              logic [15:0] im, logic [7:0] er, logic [7:0] eh, logic ei, int lat);
    vec_t v;
    v.op = op; v.fn = fn; v.a = a; v.b = b; v.im = im;
    v.er = er; v.eh = eh; v.ei = ei; v.lat = lat;
    return v;
  endfunction

  task automatic do_op(input vec_t v, input string nm);
    int n;
    int nb;
    n = 0;
    while (!in_ready && n < 50) begin @(posedge clk); #1; n++; end
    chk({nm, ".ready"}, in_ready, 1);
    opcode = v.op; func = v.fn; rsv = v.a; rtv = v.b; imm = v.im;
    in_valid = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    opcode = 6'($urandom); func = 6'($urandom); rsv = 8'($urandom);
    rtv = 8'($urandom); imm = 16'($urandom);
    n = 1; nb = 0;
    while (!out_valid && n < 50) begin
      if (!in_ready) nb++;
      @(posedge clk); #1; n++;
    end
    chk({nm, ".lat"}, n, v.lat);
    chk({nm, ".busy"}, nb, v.lat - 1);
    chk({nm, ".res"}, result, v.er);
    chk({nm, ".hi"}, result_hi, v.eh);
    chk({nm, ".inv"}, instruction_invalid, v.ei);
    @(posedge clk); #1;
  endtask

  initial begin
    vec_t tbl[$];
    vec_t v;
    logic [11:0] pairs[14];

    tbl.push_back(mk(6'h00, 6'h21, 8'hF0, 8'h20, 16'h0, 8'h10, 8'h00, 1'b0, 1));
    tbl.push_back(mk(6'h00, 6'h19, 8'hFF, 8'hFF, 16'h0, 8'h01, 8'hFE, 1'b0, 9));
    tbl.push_back(mk(6'h00, 6'h24, 8'hF0, 8'h3C, 16'h0, 8'h30, 8'h00, 1'b0, 1));
    tbl.push_back(mk(6'h00, 6'h25, 8'hF0, 8'h0F, 16'h0, 8'hFF, 8'h00, 1'b0, 1));
    tbl.push_back(mk(6'h00, 6'h26, 8'hAA, 8'hFF, 16'h0, 8'h55, 8'h00, 1'b0, 1));
    tbl.push_back(mk(6'h00, 6'h2A, 8'h80, 8'h01, 16'h0, 8'h01, 8'h00, 1'b0, 1));
    tbl.push_back(mk(6'h00, 6'h2B, 8'h80, 8'h01, 16'h0, 8'h00, 8'h00, 1'b0, 1));
    tbl.push_back(mk(6'h00, 6'h00, 8'h03, 8'h11, 16'h0, 8'h88, 8'h00, 1'b0, 1));
    tbl.push_back(mk(6'h00, 6'h02, 8'h04, 8'h80, 16'h0, 8'h08, 8'h00, 1'b0, 1));
    tbl.push_back(mk(6'h00, 6'h03, 8'h04, 8'h80, 16'h0, 8'hF8, 8'h00, 1'b0, 1));
    tbl.push_back(mk(6'h0C, 6'h00, 8'hFF, 8'h00, 16'h1234, 8'h34, 8'h00, 1'b0, 1));
    tbl.push_back(mk(6'h0D, 6'h00, 8'h01, 8'h00, 16'hFF80, 8'h81, 8'h00, 1'b0, 1));
    tbl.push_back(mk(6'h3F, 6'h21, 8'h12, 8'h34, 16'h0, 8'h00, 8'h00, 1'b1, 1));
    tbl.push_back(mk(6'h00, 6'h3F, 8'h12, 8'h34, 16'h0, 8'h00, 8'h00, 1'b1, 1));
    tbl.push_back(mk(6'h00, 6'h19, 8'h0D, 8'h0B, 16'h0, 8'h8F, 8'h00, 1'b0, 9));

    pairs = '{12'h021, 12'h023, 12'h024, 12'h025, 12'h026, 12'h02A, 12'h02B,
              12'h000, 12'h002, 12'h003, 12'h019, 12'h240, 12'h300, 12'h340};

    // Reset state
    repeat (2) @(posedge clk);
    #1;
    chk("rst.valid", out_valid, 0);
    chk("rst.res", result, 0);
    chk("rst.hi", result_hi, 0);
    chk("rst.inv", instruction_invalid, 1);
    chk("rst.ready", in_ready, 1);
    reset = 1'b0;
    @(posedge clk); #1;

    for (int i = 0; i < tbl.size(); i++) begin
      do_op(tbl[i], $sformatf("tbl%0d", i));
    end

    // Stalled consumer holds SUBU result
    opcode = 6'h00; func = 6'h23; rsv = 8'd5; rtv = 8'd7; in_valid = 1'b1; out_ready = 1'b0;
    @(posedge clk); #1;
    in_valid = 1'b0; rsv = 8'h99; rtv = 8'h11;
    for (int i = 0; i < 4; i++) begin
      chk("hold.valid", out_valid, 1);
      chk("hold.res", result, 8'hFE);
      chk("hold.ready", in_ready, 0);
      @(posedge clk); #1;
    end
    out_ready = 1'b1; #1;
    chk("hold.release_ready", in_ready, 1);
    chk("hold.release_res", result, 8'hFE);
    @(posedge clk); #1;
    chk("hold.idle", out_valid, 0);

    // Back-to-back ADDIU then SLT without a bubble
    opcode = 6'h09; func = 6'h00; rsv = 8'd3; imm = 16'h0105; in_valid = 1'b1;
    @(posedge clk); #1;
    chk("b2b.v1", out_valid, 1);
    chk("b2b.r1", result, 8'h08);
    opcode = 6'h00; func = 6'h2A; rsv = 8'h80; rtv = 8'h01; in_valid = 1'b1; #1;
    chk("b2b.ready", in_ready, 1);
    @(posedge clk); #1;
    in_valid = 1'b0;
    chk("b2b.v2", out_valid, 1);
    chk("b2b.r2", result, 8'h01);
    chk("b2b.inv2", instruction_invalid, 0);
    @(posedge clk); #1;
    chk("b2b.idle", out_valid, 0);

    // Reset during the 4th MUL cycle
    opcode = 6'h00; func = 6'h19; rsv = 8'hFF; rtv = 8'hFF; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("mrst.pre_valid", out_valid, 0);
    chk("mrst.pre_ready", in_ready, 0);
    reset = 1'b1; #1;
    chk("mrst.valid", out_valid, 0);
    chk("mrst.inv", instruction_invalid, 1);
    chk("mrst.res", result, 0);
    chk("mrst.ready", in_ready, 1);
    @(negedge clk);
    reset = 1'b0;
    @(posedge clk); #1;
    chk("mrst.after_ready", in_ready, 1);
    do_op(mk(6'h00, 6'h21, 8'h01, 8'h02, 16'h0, 8'h03, 8'h00, 1'b0, 1), "mrst.addu");

    // Random instructions against the reference model
    for (int i = 0; i < 40; i++) begin
      int k;
      logic [11:0] p;
      k = int'($urandom_range(0, 14));
      if (k == 14) p = 12'($urandom);
      else         p = pairs[k];
      v = model(p[11:6], p[5:0], 8'($urandom), 8'($urandom), 16'($urandom));
      do_op(v, $sformatf("rnd%0d", i));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout actual=running expected=finished");
    $fatal(1, "timeout");
  end

endmodule : tb_execute_mc
`default_nettype wire
